pipe_hazard_ctrl: RTL and testbench

Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-stage enable and flush (bubble) controls for load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
- Drives the EX-stage operand forwarding selects.
- Keeps a saturating stall counter and a sticky memory-timeout fault.

---
 rtl/pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: stage enables/bubbles, EX forwarding selects,
// data-memory wait handling with timeout fault, and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs_num,
    input  logic [4:0]       id_rt_num,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs_num,
    input  logic [4:0]       ex_rt_num,
    input  logic [4:0]       ex_rd_num,
    input  logic             ex_reg_write,
    input  logic             ex_mem_to_reg,
    input  logic             ex_branch,
    input  logic             ex_zero,
    input  logic [4:0]       mem_rd_num,
    input  logic             mem_reg_write,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic [4:0]       wb_rd_num,
    input  logic             wb_reg_write,
    output logic             pc_en,
    output logic             branch_taken,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             dmem_req,
    output logic [CNT_W-1:0] stall_count,
    output logic             fault
);

    localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_FAULT
    } state_t;

    state_t           r_state;
    logic [TMO_W-1:0] r_tmo;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_fault;

    logic             w_load_use;
    logic             w_branch;
    logic             w_mem_stall;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    assign w_load_use = ex_mem_to_reg & ex_reg_write & (ex_rd_num != 5'd0) &
                        ((ex_rd_num == id_rs_num) | (id_uses_rt & (ex_rd_num == id_rt_num)));
    assign w_branch   = ex_branch & ex_zero;

    // The entry cycle out of RUN already stalls, so it is covered here as well as MEM_WAIT.
    assign w_mem_stall = ((r_state == S_RUN) & mem_req & ~mem_ready) |
                         ((r_state == S_MEM_WAIT) & ~mem_ready);

    assign w_fwd_a = (mem_reg_write & (mem_rd_num != 5'd0) & (mem_rd_num == ex_rs_num)) ? 2'b10 :
                     (wb_reg_write  & (wb_rd_num  != 5'd0) & (wb_rd_num  == ex_rs_num)) ? 2'b01 :
                                                                                          2'b00;
    assign w_fwd_b = (mem_reg_write & (mem_rd_num != 5'd0) & (mem_rd_num == ex_rt_num)) ? 2'b10 :
                     (wb_reg_write  & (wb_rd_num  != 5'd0) & (wb_rd_num  == ex_rt_num)) ? 2'b01 :
                                                                                          2'b00;

    always_comb begin
        pc_en        = 1'b0;
        branch_taken = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_en     = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_flush  = 1'b0;
        fwd_a        = 2'b00;
        fwd_b        = 2'b00;
        dmem_req     = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            fwd_a = w_fwd_a;
            fwd_b = w_fwd_b;
            case (r_state)
                S_RUN, S_MEM_WAIT: begin
                    dmem_req = mem_req;
                    if (w_mem_stall) begin
                        memwb_en    = 1'b1;
                        memwb_flush = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                        // A taken branch squashes the ID instruction, so a load-use stall on it is moot.
                        if (w_branch) begin
                            branch_taken = 1'b1;
                            ifid_flush   = 1'b1;
                            idex_flush   = 1'b1;
                        end else if (w_load_use) begin
                            pc_en      = 1'b0;
                            ifid_en    = 1'b0;
                            idex_flush = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_tmo       <= '0;
            r_stall_cnt <= '0;
            r_fault     <= 1'b0;
        end else begin
            if ((r_state != S_FAULT) && !pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            case (r_state)
                S_RUN: begin
                    if (mem_req && !mem_ready) begin
                        r_state <= S_MEM_WAIT;
                        r_tmo   <= '0;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_ready) begin
                        r_state <= S_RUN;
                    end else if (r_tmo == TMO_LAST) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall_count = r_stall_cnt;
    assign fault       = r_fault;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenarios plus randomized traffic for pipe_hazard_ctrl, checked against a
// cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int TMO  = 4;
    localparam int CW   = 4;
    localparam int SMAX = (1 << CW) - 1;

    // {pc_en, branch_taken, ifid_en, idex_en, exmem_en, memwb_en,
    //  ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b, dmem_req, fault}
    localparam logic [14:0] RST_V  = 15'b0_0_0000_111_00_00_0_0;
    localparam logic [14:0] RSTF_V = 15'b0_0_0000_111_00_00_0_1;
    localparam logic [14:0] RUN_V  = 15'b1_0_1111_000_00_00_0_0;
    localparam logic [14:0] RUNM_V = 15'b1_0_1111_000_00_00_1_0;
    localparam logic [14:0] LU_V   = 15'b0_0_0111_010_00_00_0_0;
    localparam logic [14:0] BR_V   = 15'b1_1_1111_110_00_00_0_0;
    localparam logic [14:0] BRM_V  = 15'b1_1_1111_110_00_00_1_0;
    localparam logic [14:0] STL_V  = 15'b0_0_0001_001_00_00_1_0;
    localparam logic [14:0] FLT_V  = 15'b0_0_0000_000_00_00_0_1;

    logic          clk;
    logic          rst;
    logic [4:0]    id_rs_num, id_rt_num, ex_rs_num, ex_rt_num, ex_rd_num;
    logic [4:0]    mem_rd_num, wb_rd_num;
    logic          id_uses_rt, ex_reg_write, ex_mem_to_reg, ex_branch, ex_zero;
    logic          mem_reg_write, mem_req, mem_ready, wb_reg_write;
    logic          pc_en, branch_taken, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, memwb_flush, dmem_req, fault;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_count;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    bit m_wait;
    int m_wcnt;
    bit m_fault;
    int m_stalls;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs_num(id_rs_num), .id_rt_num(id_rt_num), .id_uses_rt(id_uses_rt),
        .ex_rs_num(ex_rs_num), .ex_rt_num(ex_rt_num), .ex_rd_num(ex_rd_num),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .ex_zero(ex_zero),
        .mem_rd_num(mem_rd_num), .mem_reg_write(mem_reg_write),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_rd_num(wb_rd_num), .wb_reg_write(wb_reg_write),
        .pc_en(pc_en), .branch_taken(branch_taken),
        .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .dmem_req(dmem_req),
        .stall_count(stall_count), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] outs_now();
        return {pc_en, branch_taken, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b, dmem_req, fault};
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (mem_reg_write && mem_rd_num != 0 && mem_rd_num == src) return 2'b10;
        if (wb_reg_write && wb_rd_num != 0 && wb_rd_num == src)    return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [14:0] exp_outs();
        logic [5:0] en;   // pc, bt, ifid, idex, exmem, memwb
        logic [2:0] fl;
        logic [1:0] fa, fb;
        logic       dm, waiting, lu, br;
        en = '0; fl = '0; fa = 2'b00; fb = 2'b00; dm = 1'b0;
        if (rst) begin
            fl = 3'b111;
        end else if (m_fault) begin
            fa = exp_fwd(ex_rs_num);
            fb = exp_fwd(ex_rt_num);
        end else begin
            fa = exp_fwd(ex_rs_num);
            fb = exp_fwd(ex_rt_num);
            dm = mem_req;
            waiting = !mem_ready && (m_wait || mem_req);
            lu = ex_mem_to_reg && ex_reg_write && ex_rd_num != 0 &&
                 (ex_rd_num == id_rs_num || (id_uses_rt && ex_rd_num == id_rt_num));
            br = ex_branch && ex_zero;
            if (waiting)  begin en = 6'b000001; fl = 3'b001; end
            else if (br)  begin en = 6'b111111; fl = 3'b110; end
            else if (lu)  begin en = 6'b000111; fl = 3'b010; end
            else          begin en = 6'b101111; fl = 3'b000; end
        end
        return {en, fl, fa, fb, dm, m_fault};
    endfunction

    task automatic model_step();
        logic [14:0] e;
        e = exp_outs();
        if (rst) begin
            m_wait = 0; m_wcnt = 0; m_fault = 0; m_stalls = 0;
        end else if (!m_fault) begin
            if (!e[14]) m_stalls = (m_stalls < SMAX) ? m_stalls + 1 : SMAX;
            if (!m_wait) begin
                if (mem_req && !mem_ready) begin m_wait = 1; m_wcnt = 0; end
            end else if (mem_ready) begin
                m_wait = 0;
            end else begin
                m_wcnt++;
                if (m_wcnt == TMO) begin m_fault = 1; m_wait = 0; end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        id_rs_num = 0; id_rt_num = 0; id_uses_rt = 0;
        ex_rs_num = 0; ex_rt_num = 0; ex_rd_num = 0;
        ex_reg_write = 0; ex_mem_to_reg = 0; ex_branch = 0; ex_zero = 0;
        mem_rd_num = 0; mem_reg_write = 0; mem_req = 0; mem_ready = 0;
        wb_rd_num = 0; wb_reg_write = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1;
        repeat (2) tick();
        rst = 0;
    endtask

    task automatic set_load_use();
        ex_mem_to_reg = 1; ex_reg_write = 1; ex_rd_num = 5; id_rs_num = 5;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_total++;
            if (outs_now() !== RST_V) $display("FAIL reset_outs[%0d]: got %b want %b", i, outs_now(), RST_V);
            else n_pass++;
            tick();
        end
        rst = 0;
        @(negedge clk);
        n_total++;
        if (outs_now() !== RUN_V) $display("FAIL post_reset_outs: got %b want %b", outs_now(), RUN_V);
        else n_pass++;
        n_total++;
        if (stall_count !== 0) $display("FAIL post_reset_stall_count: got %0d want 0", stall_count);
        else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        reset_dut();
        set_load_use();
        @(negedge clk);
        n_total++;
        if (outs_now() !== LU_V) $display("FAIL load_use_rs: got %b want %b", outs_now(), LU_V);
        else n_pass++;
        tick();
        ex_mem_to_reg = 0;
        @(negedge clk);
        n_total++;
        if (outs_now() !== RUN_V) $display("FAIL load_use_single_bubble: got %b want %b", outs_now(), RUN_V);
        else n_pass++;
        n_total++;
        if (stall_count !== 1) $display("FAIL load_use_stall_count: got %0d want 1", stall_count);
        else n_pass++;
        tick();
        ex_mem_to_reg = 1; ex_rd_num = 0; id_rs_num = 0;
        @(negedge clk);
        n_total++;
        if (outs_now() !== RUN_V) $display("FAIL load_use_rd0: got %b want %b", outs_now(), RUN_V);
        else n_pass++;
        tick();
        ex_rd_num = 9; id_rs_num = 3; id_rt_num = 9; id_uses_rt = 1;
        @(negedge clk);
        n_total++;
        if (outs_now() !== LU_V) $display("FAIL load_use_rt: got %b want %b", outs_now(), LU_V);
        else n_pass++;
        tick();
        id_uses_rt = 0;
        @(negedge clk);
        n_total++;
        if (outs_now() !== RUN_V) $display("FAIL load_use_rt_unused: got %b want %b", outs_now(), RUN_V);
        else n_pass++;
        tick();
    endtask

    task automatic test_branch_load_use();
        reset_dut();
        set_load_use();
        ex_branch = 1; ex_zero = 1;
        @(negedge clk);
        n_total++;
        if (outs_now() !== BR_V) $display("FAIL branch_over_load_use: got %b want %b", outs_now(), BR_V);
        else n_pass++;
        tick();
        ex_zero = 0;
        @(negedge clk);
        n_total++;
        if (outs_now() !== LU_V) $display("FAIL branch_not_taken_lu: got %b want %b", outs_now(), LU_V);
        else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_total++;
        if (stall_count !== 1) $display("FAIL branch_stall_count: got %0d want 1", stall_count);
        else n_pass++;
        tick();
    endtask

    task automatic test_mem_wait();
        reset_dut();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin ex_branch = 1; ex_zero = 1; end
            @(negedge clk);
            n_total++;
            if (outs_now() !== STL_V) $display("FAIL mem_wait_stall[%0d]: got %b want %b", i, outs_now(), STL_V);
            else n_pass++;
            tick();
        end
        mem_ready = 1;
        @(negedge clk);
        n_total++;
        if (outs_now() !== BRM_V) $display("FAIL mem_release_branch: got %b want %b", outs_now(), BRM_V);
        else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_total++;
        if (outs_now() !== RUN_V) $display("FAIL mem_back_in_run: got %b want %b", outs_now(), RUN_V);
        else n_pass++;
        n_total++;
        if (stall_count !== 3) $display("FAIL mem_wait_stall_count: got %0d want 3", stall_count);
        else n_pass++;
        tick();
        mem_req = 1; mem_ready = 1;
        @(negedge clk);
        n_total++;
        if (outs_now() !== RUNM_V) $display("FAIL mem_zero_wait: got %b want %b", outs_now(), RUNM_V);
        else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_total++;
        if (stall_count !== 3) $display("FAIL mem_zero_wait_count: got %0d want 3", stall_count);
        else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        reset_dut();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < TMO + 1; i++) begin
            @(negedge clk);
            n_total++;
            if (outs_now() !== STL_V) $display("FAIL timeout_stall[%0d]: got %b want %b", i, outs_now(), STL_V);
            else n_pass++;
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 1) mem_ready = 1;
            @(negedge clk);
            n_total++;
            if (outs_now() !== FLT_V) $display("FAIL fault_state[%0d]: got %b want %b", i, outs_now(), FLT_V);
            else n_pass++;
            n_total++;
            if (stall_count !== TMO + 1) $display("FAIL fault_stall_count[%0d]: got %0d want %0d", i, stall_count, TMO + 1);
            else n_pass++;
            tick();
        end
        idle_inputs();
        rst = 1;
        @(negedge clk);
        n_total++;
        if (outs_now() !== RSTF_V) $display("FAIL fault_during_rst: got %b want %b", outs_now(), RSTF_V);
        else n_pass++;
        tick();
        rst = 0;
        @(negedge clk);
        n_total++;
        if (outs_now() !== RUN_V) $display("FAIL fault_cleared: got %b want %b", outs_now(), RUN_V);
        else n_pass++;
        tick();
    endtask

    task automatic test_forwarding();
        reset_dut();
        mem_rd_num = 7; wb_rd_num = 7; mem_reg_write = 1; wb_reg_write = 1;
        ex_rs_num = 7; ex_rt_num = 7;
        @(negedge clk);
        n_total++;
        if ({fwd_a, fwd_b} !== 4'b1010) $display("FAIL fwd_mem_priority: got %b want 1010", {fwd_a, fwd_b});
        else n_pass++;
        mem_reg_write = 0;
        #1;
        n_total++;
        if ({fwd_a, fwd_b} !== 4'b0101) $display("FAIL fwd_wb: got %b want 0101", {fwd_a, fwd_b});
        else n_pass++;
        mem_reg_write = 1; mem_rd_num = 0; wb_rd_num = 0;
        #1;
        n_total++;
        if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL fwd_rd0: got %b want 0000", {fwd_a, fwd_b});
        else n_pass++;
        mem_rd_num = 7; wb_rd_num = 3; ex_rt_num = 3;
        #1;
        n_total++;
        if ({fwd_a, fwd_b} !== 4'b1001) $display("FAIL fwd_split: got %b want 1001", {fwd_a, fwd_b});
        else n_pass++;
        tick();
        idle_inputs();
    endtask

    task automatic test_saturation();
        reset_dut();
        set_load_use();
        repeat (SMAX + 3) tick();
        @(negedge clk);
        n_total++;
        if (stall_count !== SMAX) $display("FAIL stall_saturate: got %0d want %0d", stall_count, SMAX);
        else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_total++;
        if (stall_count !== SMAX) $display("FAIL stall_hold_max: got %0d want %0d", stall_count, SMAX);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [14:0] e;
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            rst           = ($urandom_range(0, 39) == 0);
            id_rs_num     = 5'($urandom_range(0, 3));
            id_rt_num     = 5'($urandom_range(0, 3));
            id_uses_rt    = 1'($urandom);
            ex_rs_num     = 5'($urandom_range(0, 3));
            ex_rt_num     = 5'($urandom_range(0, 3));
            ex_rd_num     = 5'($urandom_range(0, 3));
            ex_reg_write  = 1'($urandom);
            ex_mem_to_reg = 1'($urandom);
            ex_branch     = ($urandom_range(0, 3) == 0);
            ex_zero       = 1'($urandom);
            mem_rd_num    = 5'($urandom_range(0, 3));
            mem_reg_write = 1'($urandom);
            mem_req       = ($urandom_range(0, 2) == 0);
            mem_ready     = ($urandom_range(0, 4) < 2);
            wb_rd_num     = 5'($urandom_range(0, 3));
            wb_reg_write  = 1'($urandom);
            @(negedge clk);
            e = exp_outs();
            n_total++;
            if (outs_now() !== e) $display("FAIL rand_outs[%0d]: got %b want %b", c, outs_now(), e);
            else n_pass++;
            n_total++;
            if (stall_count !== CW'(m_stalls)) $display("FAIL rand_stall_count[%0d]: got %0d want %0d", c, stall_count, m_stalls);
            else n_pass++;
            tick();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        m_wait = 0; m_wcnt = 0; m_fault = 0; m_stalls = 0;
        rst = 1;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_mem_wait();
        test_timeout();
        test_forwarding();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
